// File: rtl/lcd_char_receiver.sv
// Display-side HD44780-style responder: latches bytes on the falling edge of enable and keeps a 2x16 buffer.
// Define LCD_RCV_BUSY_EN to model busy/overrun and the timed clear sweep; otherwise every strobe is taken at once.
module lcd_char_receiver #(
    parameter int LINE_CHARS  = 16,
    parameter int BUSY_CYCLES = 4
) (
    input  logic       fpga_clk_i,
    input  logic       fpga_reset_i,
    input  logic [7:0] lcd_data_i,
    input  logic       lcd_reset_i,
    input  logic       lcd_enable_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_char_o,
    output logic [4:0] cursor_o,
    output logic       busy_o,
    output logic       display_on_o,
    output logic       two_line_o,
    output logic       overrun_o
);

    localparam int CELLS = 2 * LINE_CHARS;

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

`ifdef LCD_RCV_BUSY_EN
    localparam state_t AFTER_CMD = EXEC;
`else
    localparam state_t AFTER_CMD = IDLE;
`endif

    state_t      state_q, state_d;
    logic        en_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  clr_idx_q, clr_idx_d;
    logic [7:0]  cells_q [CELLS];
    logic [7:0]  cells_d [CELLS];
    logic [4:0]  cursor_q, cursor_d;
    logic        inc_q, inc_d;
    logic        disp_q, disp_d;
    logic        two_q, two_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  rd_char_q, rd_char_d;
    logic        strobe;
    logic        accept;

    // Two-line mode walks all 32 cells; one-line mode wraps the column within the current line.
    function automatic logic [4:0] step(input logic [4:0] cur, input logic up, input logic two);
        logic [4:0] r;
        if (two) r = up ? cur + 5'd1 : cur - 5'd1;
        else     r = {cur[4], (up ? cur[3:0] + 4'd1 : cur[3:0] - 4'd1)};
        return r;
    endfunction

    always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
        if (fpga_reset_i) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            cnt_q     <= '0;
            clr_idx_q <= '0;
            for (int unsigned i = 0; i < CELLS; i++) cells_q[i] <= 8'h20;
            cursor_q  <= '0;
            inc_q     <= 1'b1;
            disp_q    <= 1'b0;
            two_q     <= 1'b1;
            ovr_q     <= 1'b0;
            rd_char_q <= 8'h20;
        end else begin
            state_q   <= state_d;
            en_q      <= lcd_enable_i;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            for (int unsigned i = 0; i < CELLS; i++) cells_q[i] <= cells_d[i];
            cursor_q  <= cursor_d;
            inc_q     <= inc_d;
            disp_q    <= disp_d;
            two_q     <= two_d;
            ovr_q     <= ovr_d;
            rd_char_q <= rd_char_d;
        end
    end

    assign strobe = en_q & ~lcd_enable_i;

    // A strobe landing on the final busy cycle is taken, since busy is judged before it expires.
`ifdef LCD_RCV_BUSY_EN
    assign accept = (state_q == IDLE) ||
                    ((state_q == EXEC) && (cnt_q == 8'd0)) ||
                    ((state_q == CLEAR) && clr_idx_q[5]);
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        for (int unsigned i = 0; i < CELLS; i++) cells_d[i] = cells_q[i];
        cursor_d  = cursor_q;
        inc_d     = inc_q;
        disp_d    = disp_q;
        two_d     = two_q;
        ovr_d     = ovr_q;
        rd_char_d = cells_q[rd_addr_i];

        case (state_q)
            EXEC: begin
                if (cnt_q == 8'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            CLEAR: begin
                if (clr_idx_q[5]) begin
                    state_d = IDLE;
                end else begin
                    cells_d[clr_idx_q[4:0]] = 8'h20;
                    clr_idx_d = clr_idx_q + 6'd1;
                end
            end
            default: ;
        endcase

        if (strobe) begin
            if (!accept) begin
                ovr_d = 1'b1;
            end else begin
                state_d = AFTER_CMD;
                cnt_d   = 8'(BUSY_CYCLES - 1);
                if (lcd_reset_i) begin
                    cells_d[cursor_q] = lcd_data_i;
                    cursor_d = step(cursor_q, inc_q, two_q);
                end else begin
                    casez (lcd_data_i)
                        8'b1???????: cursor_d = {lcd_data_i[6], lcd_data_i[3:0]};
                        8'b01??????: ;
                        8'b001?????: two_d = lcd_data_i[3];
                        8'b0001????: if (!lcd_data_i[3]) cursor_d = step(cursor_q, lcd_data_i[2], two_q);
                        8'b00001???: disp_d = lcd_data_i[2];
                        8'b000001??: inc_d = lcd_data_i[1];
                        8'b0000001?: cursor_d = '0;
                        8'b00000001: begin
                            cursor_d = '0;
                            inc_d    = 1'b1;
`ifdef LCD_RCV_BUSY_EN
                            state_d   = CLEAR;
                            clr_idx_d = '0;
`else
                            for (int unsigned i = 0; i < CELLS; i++) cells_d[i] = 8'h20;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_char_o    = rd_char_q;
        cursor_o     = cursor_q;
        busy_o       = (state_q != IDLE);
        display_on_o = disp_q;
        two_line_o   = two_q;
        overrun_o    = ovr_q;
    end

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Directed bench for lcd_char_receiver; readback expectations go through a scoreboard queue.
module tb_lcd_char_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lcd_data = '0;
    logic       lcd_rs = 1'b0;
    logic       lcd_en = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       busy, disp_on, two_line, overrun;

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] sb [$];

`ifdef LCD_RCV_BUSY_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    lcd_char_receiver #(.LINE_CHARS(16), .BUSY_CYCLES(4)) dut (
        .fpga_clk_i(clk),
        .fpga_reset_i(rst),
        .lcd_data_i(lcd_data),
        .lcd_reset_i(lcd_rs),
        .lcd_enable_i(lcd_en),
        .rd_addr_i(rd_addr),
        .rd_char_o(rd_char),
        .cursor_o(cursor),
        .busy_o(busy),
        .display_on_o(disp_on),
        .two_line_o(two_line),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        lcd_rs   = rs;
        lcd_data = d;
        lcd_en   = 1'b1;
        tick();
        lcd_en   = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic send_w(input logic rs, input logic [7:0] d);
        send(rs, d);
        wait_idle();
    endtask

    task automatic read_cell(input string tag, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] e;
        rd_addr = a;
        sb.push_back(exp);
        tick();
        e = sb.pop_front();
        check(tag, {24'd0, rd_char}, {24'd0, e});
    endtask

    task automatic busy_len(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check(tag, n, BUSY_EN ? 32'd4 : 32'd0);
    endtask

    initial begin
        int cyc;
        int busy_fall;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_cursor", {27'd0, cursor}, 32'd0);
        check("rst_two_line", {31'd0, two_line}, 32'd1);
        check("rst_disp", {31'd0, disp_on}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rd_char", {24'd0, rd_char}, 32'h20);
        for (int i = 0; i < 32; i++) read_cell("rst_cell", 5'(i), 8'h20);

        // Two data bytes with busy window measurement
        send(1'b1, 8'h48);
        busy_len("busy_len_1");
        repeat (5) tick();
        send(1'b1, 8'h65);
        busy_len("busy_len_2");
        repeat (5) tick();
        check("cursor_after_2", {27'd0, cursor}, 32'd2);
        read_cell("cell0_48", 5'd0, 8'h48);
        read_cell("cell1_65", 5'd1, 8'h65);

        // Line boundary and 31 -> 0 wrap
        send_w(1'b0, 8'h8F);
        check("cursor_8f", {27'd0, cursor}, 32'd15);
        send_w(1'b1, 8'h41);
        send_w(1'b1, 8'h42);
        check("cursor_17", {27'd0, cursor}, 32'd17);
        read_cell("cell15_41", 5'd15, 8'h41);
        read_cell("cell16_42", 5'd16, 8'h42);
        send_w(1'b0, 8'h9F);
        check("cursor_9f_ignores_b54", {27'd0, cursor}, 32'd15);
        send_w(1'b0, 8'hCF);
        check("cursor_cf", {27'd0, cursor}, 32'd31);
        send_w(1'b1, 8'h41);
        send_w(1'b1, 8'h42);
        check("cursor_wrap_1", {27'd0, cursor}, 32'd1);
        read_cell("cell31_41", 5'd31, 8'h41);
        read_cell("cell0_42", 5'd0, 8'h42);

        // Fill, then clear with a strobe arriving mid-sweep
        send_w(1'b0, 8'h80);
        for (int i = 0; i < 32; i++) send_w(1'b1, 8'(8'h30 + i));
        read_cell("fill_cell5", 5'd5, 8'h35);
        read_cell("fill_cell31", 5'd31, 8'h4F);
        send(1'b0, 8'h01);
        cyc = 0;
        busy_fall = busy ? -1 : 0;
        while (cyc < 60 && (busy || cyc < 12)) begin
            if (cyc == 8) begin
                lcd_rs = 1'b1;
                lcd_data = 8'h55;
                lcd_en = 1'b1;
            end
            if (cyc == 9) lcd_en = 1'b0;
            tick();
            cyc++;
            if (busy_fall < 0 && !busy) busy_fall = cyc;
        end
        check("clear_busy_fall", busy_fall, BUSY_EN ? 32'd33 : 32'd0);
        check("clear_overrun", {31'd0, overrun}, {31'd0, BUSY_EN});
        check("clear_cursor", {27'd0, cursor}, BUSY_EN ? 32'd0 : 32'd1);
        read_cell("clear_cell0", 5'd0, BUSY_EN ? 8'h20 : 8'h55);
        for (int i = 1; i < 32; i++) read_cell("clear_cell", 5'(i), 8'h20);

        // One-line decrement and mode commands
        if (!BUSY_EN) send_w(1'b0, 8'h02);
        send_w(1'b0, 8'h20);
        check("one_line", {31'd0, two_line}, 32'd0);
        send_w(1'b0, 8'h04);
        send_w(1'b0, 8'h80);
        send_w(1'b1, 8'h58);
        check("cursor_dec_wrap", {27'd0, cursor}, 32'd15);
        read_cell("cell0_58", 5'd0, 8'h58);
        send_w(1'b1, 8'h59);
        check("cursor_14", {27'd0, cursor}, 32'd14);
        read_cell("cell15_59", 5'd15, 8'h59);
        send_w(1'b0, 8'h10);
        check("shift_left", {27'd0, cursor}, 32'd13);
        send_w(1'b0, 8'h14);
        check("shift_right", {27'd0, cursor}, 32'd14);
        send_w(1'b0, 8'h18);
        check("shift_display", {27'd0, cursor}, 32'd14);
        send_w(1'b0, 8'h40);
        send_w(1'b0, 8'h00);
        check("cgram_nop", {27'd0, cursor}, 32'd14);
        send_w(1'b0, 8'h0C);
        check("disp_on", {31'd0, disp_on}, 32'd1);
        send_w(1'b0, 8'h08);
        check("disp_off", {31'd0, disp_on}, 32'd0);
        send_w(1'b0, 8'h28);
        check("two_line_set", {31'd0, two_line}, 32'd1);
        send_w(1'b0, 8'h80);
        send_w(1'b1, 8'h61);
        check("dec_wrap_31", {27'd0, cursor}, 32'd31);
        read_cell("cell0_61", 5'd0, 8'h61);
        send_w(1'b0, 8'h20);
        send_w(1'b0, 8'h06);
        send_w(1'b0, 8'hCF);
        send_w(1'b1, 8'h62);
        check("one_line_inc_wrap", {27'd0, cursor}, 32'd16);
        read_cell("cell31_62", 5'd31, 8'h62);
        send_w(1'b0, 8'h02);
        check("home", {27'd0, cursor}, 32'd0);

        // Reset in the middle of a clear sweep
        send_w(1'b0, 8'h0C);
        send_w(1'b0, 8'hC5);
        check("pre_reset_overrun", {31'd0, overrun}, {31'd0, BUSY_EN});
        send(1'b0, 8'h01);
        repeat (11) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        check("mid_rst_cursor", {27'd0, cursor}, 32'd0);
        check("mid_rst_disp", {31'd0, disp_on}, 32'd0);
        check("mid_rst_two_line", {31'd0, two_line}, 32'd1);
        check("mid_rst_rd_char", {24'd0, rd_char}, 32'h20);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        for (int i = 0; i < 32; i++) read_cell("post_rst_cell", 5'(i), 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
